// File: rtl/hamming_tx_pkg.sv
// Shared types and elaboration-time helpers for the extended-Hamming TX path.
// The serializer and the encoder both import this package.
package hamming_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int calc_beats(input int cw_w, input int out_w);
        return cw_w / out_w;
    endfunction

    // Smallest m with 2^m >= m + k + 1. It matches the encoder's check-bit count.
    function automatic int calc_m(input int k);
        int m;
        m = 0;
        for (int i = 30; i >= 1; i--) begin
            if ((1 << i) >= i + k + 1) m = i;
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_tx_serializer.sv
// Splits one encoded codeword into CW_W/OUT_W lane beats with sof/eof markers.
// A new word loads on the final beat, so back-to-back codewords leave no bubble.
module hamming_tx_serializer
    import hamming_tx_pkg::*;
#(
    parameter int CW_W      = 32,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CW_W-1:0]  cw_i,
    input  logic             cw_valid_i,
    output logic             cw_ready_o,
    output logic [OUT_W-1:0] ser_o,
    output logic             ser_valid_o,
    input  logic             ser_ready_i,
    output logic             ser_sof_o,
    output logic             ser_eof_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] cw_count_o
);

    localparam int BEATS  = calc_beats(CW_W, OUT_W);
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCNT_W-1:0] LAST = BCNT_W'(BEATS - 1);

    generate
        if ((CW_W % OUT_W) != 0) begin : g_bad_width
            $error("hamming_tx_serializer: CW_W must be a multiple of OUT_W");
        end
    endgenerate

    state_t             state, state_next;
    logic [CW_W-1:0]    shreg;
    logic [BCNT_W-1:0]  cnt;
    logic               sof, eof;
    logic [CNT_W-1:0]   count;
    logic               last_beat, beat_done, accept;

    function automatic logic [CW_W-1:0] advance(input logic [CW_W-1:0] v);
        if (MSB_FIRST != 0) return v << OUT_W;
        else                return v >> OUT_W;
    endfunction

    assign last_beat = (cnt == LAST);
    assign beat_done = (state == SHIFT) && ser_ready_i;
    assign accept    = cw_valid_i && cw_ready_o;

    always_comb begin
        cw_ready_o = !rst_i && ((state == IDLE) || (beat_done && last_beat));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (beat_done && last_beat && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // The active beat always sits at the output end of the shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg <= '0;
            cnt   <= '0;
            sof   <= 1'b0;
            eof   <= 1'b0;
            count <= '0;
        end else begin
            if (accept) begin
                shreg <= cw_i;
                cnt   <= '0;
                sof   <= 1'b1;
                eof   <= (BEATS == 1);
            end else if (beat_done) begin
                shreg <= advance(shreg);
                cnt   <= last_beat ? '0 : cnt + 1'b1;
                sof   <= 1'b0;
                eof   <= !last_beat && ((cnt + 1'b1) == LAST);
            end
            if (beat_done && last_beat) count <= count + 1'b1;
        end
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign ser_o = shreg[CW_W-1 -: OUT_W];
        end else begin : g_lsb
            assign ser_o = shreg[OUT_W-1:0];
        end
    endgenerate

    assign ser_valid_o = (state == SHIFT);
    assign busy_o      = (state == SHIFT);
    assign ser_sof_o   = sof;
    assign ser_eof_o   = eof;
    assign cw_count_o  = count;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Scoreboard bench: three serializer instances (defaults, LSB-first, 4-bit counter).
// Expected beats are queued on each input handshake and compared with the beats the lane accepts.
module tb_hamming_tx_serializer;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst       [3];
    logic [31:0] cw        [3];
    logic        cw_valid  [3];
    logic        cw_ready  [3];
    logic [7:0]  ser       [3];
    logic        ser_valid [3];
    logic        ser_ready [3];
    logic        sof       [3];
    logic        eof       [3];
    logic        busy      [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    passed = 0;
    int    total  = 0;

    always #5 clk = ~clk;

    hamming_tx_serializer #(.CW_W(32), .OUT_W(8), .MSB_FIRST(1), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .cw_i(cw[0]), .cw_valid_i(cw_valid[0]),
        .cw_ready_o(cw_ready[0]), .ser_o(ser[0]), .ser_valid_o(ser_valid[0]),
        .ser_ready_i(ser_ready[0]), .ser_sof_o(sof[0]), .ser_eof_o(eof[0]),
        .busy_o(busy[0]), .cw_count_o(cnt0));

    hamming_tx_serializer #(.CW_W(32), .OUT_W(8), .MSB_FIRST(0), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .cw_i(cw[1]), .cw_valid_i(cw_valid[1]),
        .cw_ready_o(cw_ready[1]), .ser_o(ser[1]), .ser_valid_o(ser_valid[1]),
        .ser_ready_i(ser_ready[1]), .ser_sof_o(sof[1]), .ser_eof_o(eof[1]),
        .busy_o(busy[1]), .cw_count_o(cnt1));

    hamming_tx_serializer #(.CW_W(32), .OUT_W(8), .MSB_FIRST(1), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst[2]), .cw_i(cw[2]), .cw_valid_i(cw_valid[2]),
        .cw_ready_o(cw_ready[2]), .ser_o(ser[2]), .ser_valid_o(ser_valid[2]),
        .ser_ready_i(ser_ready[2]), .ser_sof_o(sof[2]), .ser_eof_o(eof[2]),
        .busy_o(busy[2]), .cw_count_o(cnt2));

    // One clock for instance i: record the handshakes at negedge, then return 1 ns after posedge.
    task automatic step(input int i);
        beat_t t;
        @(negedge clk);
        if (ser_valid[i] && ser_ready[i]) begin
            t.d = ser[i]; t.s = sof[i]; t.e = eof[i];
            obs_q.push_back(t);
        end
        if (cw_valid[i] && cw_ready[i]) begin
            for (int b = 0; b < 4; b++) begin
                t.d = (i == 1) ? cw[i][8*b +: 8] : cw[i][31-8*b -: 8];
                t.s = (b == 0);
                t.e = (b == 3);
                exp_q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; cw[i] = '0; cw_valid[i] = 1'b0; ser_ready[i] = 1'b0;
        end
        step(0); step(0);
        total++; if (cw_ready[0] !== 1'b0) $display("FAIL reset_ready: got %b want 0", cw_ready[0]); else passed++;
        total++; if (ser_valid[0] !== 1'b0) $display("FAIL reset_valid: got %b want 0", ser_valid[0]); else passed++;
        total++; if (ser[0] !== 8'h00) $display("FAIL reset_ser: got %h want 00", ser[0]); else passed++;
        total++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy[0]); else passed++;
        total++; if (cnt0 !== 16'd0) $display("FAIL reset_count: got %0d want 0", cnt0); else passed++;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        #1;
        total++; if (cw_ready[0] !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cw_ready[0]); else passed++;
        total++; if (cw_ready[1] !== 1'b1) $display("FAIL reset_release_ready1: got %b want 1", cw_ready[1]); else passed++;
    endtask

    task automatic test_single();
        beat_t o, e;
        exp_q.delete(); obs_q.delete();
        cw[0] = 32'hDEADBEEF; cw_valid[0] = 1'b1; ser_ready[0] = 1'b1;
        #1;
        total++; if (cw_ready[0] !== 1'b1) $display("FAIL single_ready: got %b want 1", cw_ready[0]); else passed++;
        step(0);
        cw_valid[0] = 1'b0;
        total++; if ({ser_valid[0], ser[0], sof[0], eof[0]} !== {1'b1, 8'hDE, 1'b1, 1'b0})
            $display("FAIL single_first: got v%b %h s%b e%b want v1 de s1 e0", ser_valid[0], ser[0], sof[0], eof[0]);
        else passed++;
        repeat (4) step(0);
        total++; if (busy[0] !== 1'b0) $display("FAIL single_busy: got %b want 0", busy[0]); else passed++;
        total++; if (cnt0 !== 16'd1) $display("FAIL single_count: got %0d want 1", cnt0); else passed++;
        total++; if (obs_q.size() != 4) $display("FAIL single_nbeats: got %0d want 4", obs_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) $display("FAIL single_beat: got %h want %h", o, e); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        beat_t o, e;
        exp_q.delete(); obs_q.delete();
        cw[0] = 32'h01234567; cw_valid[0] = 1'b1; ser_ready[0] = 1'b1;
        step(0);
        cw[0] = 32'h89ABCDEF;
        total++; if (cw_ready[0] !== 1'b0) $display("FAIL b2b_ready_mid: got %b want 0", cw_ready[0]); else passed++;
        repeat (3) step(0);
        total++; if (cw_ready[0] !== 1'b1) $display("FAIL b2b_ready_t4: got %b want 1", cw_ready[0]); else passed++;
        step(0);
        cw_valid[0] = 1'b0;
        repeat (4) step(0);
        total++; if (cnt0 !== 16'd3) $display("FAIL b2b_count: got %0d want 3", cnt0); else passed++;
        total++; if (obs_q.size() != 8) $display("FAIL b2b_nbeats: got %0d want 8", obs_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) $display("FAIL b2b_beat: got %h want %h", o, e); else passed++;
        end
    endtask

    task automatic test_stall();
        beat_t o, e;
        exp_q.delete(); obs_q.delete();
        cw[0] = 32'hDEADBEEF; cw_valid[0] = 1'b1; ser_ready[0] = 1'b1;
        step(0);
        cw_valid[0] = 1'b0;
        step(0);
        ser_ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if ({ser_valid[0], ser[0], sof[0], eof[0], cw_ready[0]} !== {1'b1, 8'hAD, 3'b000})
                $display("FAIL stall_hold%0d: got v%b %h s%b e%b r%b want v1 ad s0 e0 r0",
                         k, ser_valid[0], ser[0], sof[0], eof[0], cw_ready[0]);
            else passed++;
            if (k < 3) step(0);
        end
        ser_ready[0] = 1'b1;
        repeat (4) step(0);
        total++; if (cnt0 !== 16'd4) $display("FAIL stall_count: got %0d want 4", cnt0); else passed++;
        total++; if (obs_q.size() != 4) $display("FAIL stall_nbeats: got %0d want 4", obs_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) $display("FAIL stall_beat: got %h want %h", o, e); else passed++;
        end
    endtask

    task automatic test_lsb_first();
        beat_t o, e;
        exp_q.delete(); obs_q.delete();
        cw[1] = 32'hDEADBEEF; cw_valid[1] = 1'b1; ser_ready[1] = 1'b1;
        step(1);
        cw_valid[1] = 1'b0;
        total++; if ({ser[1], sof[1]} !== {8'hEF, 1'b1}) $display("FAIL lsb_first: got %h s%b want ef s1", ser[1], sof[1]); else passed++;
        repeat (5) step(1);
        total++; if (cnt1 !== 16'd1) $display("FAIL lsb_count: got %0d want 1", cnt1); else passed++;
        total++; if (obs_q.size() != 4) $display("FAIL lsb_nbeats: got %0d want 4", obs_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) $display("FAIL lsb_beat: got %h want %h", o, e); else passed++;
        end
    endtask

    task automatic test_mid_reset();
        beat_t o, e;
        cw[0] = 32'hDEADBEEF; cw_valid[0] = 1'b1; ser_ready[0] = 1'b1;
        step(0);
        cw_valid[0] = 1'b0;
        step(0); step(0);
        rst[0] = 1'b1;
        step(0);
        total++; if ({ser_valid[0], ser[0], sof[0], eof[0], busy[0], cw_ready[0]} !== 13'd0)
            $display("FAIL midrst_outputs: got v%b %h s%b e%b b%b r%b want all 0",
                     ser_valid[0], ser[0], sof[0], eof[0], busy[0], cw_ready[0]);
        else passed++;
        total++; if (cnt0 !== 16'd0) $display("FAIL midrst_count: got %0d want 0", cnt0); else passed++;
        rst[0] = 1'b0;
        exp_q.delete(); obs_q.delete();
        #1;
        total++; if (cw_ready[0] !== 1'b1) $display("FAIL midrst_ready: got %b want 1", cw_ready[0]); else passed++;
        cw[0] = 32'hCAFEF00D; cw_valid[0] = 1'b1;
        step(0);
        cw_valid[0] = 1'b0;
        total++; if ({ser[0], sof[0]} !== {8'hCA, 1'b1}) $display("FAIL midrst_first: got %h s%b want ca s1", ser[0], sof[0]); else passed++;
        repeat (5) step(0);
        total++; if (cnt0 !== 16'd1) $display("FAIL midrst_count_after: got %0d want 1", cnt0); else passed++;
        total++; if (obs_q.size() != 4) $display("FAIL midrst_nbeats: got %0d want 4", obs_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) $display("FAIL midrst_beat: got %h want %h", o, e); else passed++;
        end
    endtask

    task automatic test_count_wrap();
        beat_t o, e;
        logic [3:0] want;
        exp_q.delete(); obs_q.delete();
        ser_ready[2] = 1'b1;
        for (int w = 0; w < 16; w++) begin
            cw[2] = $urandom; cw_valid[2] = 1'b1;
            step(2);
            cw_valid[2] = 1'b0;
            repeat (4) step(2);
            want = 4'(w + 1);
            total++; if (cnt2 !== want) $display("FAIL wrap_count%0d: got %0d want %0d", w, cnt2, want); else passed++;
        end
        total++; if (obs_q.size() != 64) $display("FAIL wrap_nbeats: got %0d want 64", obs_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) $display("FAIL wrap_beat: got %h want %h", o, e); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_mid_reset();
        test_count_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
